// File: rtl/analog_pkg.sv
// Shared types and helpers for the multi-channel analog scan averager.
package analog_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } state_e;

    // Width of every ADC channel number (request, sample tag, update tag).
    localparam int CH_W = 4;

    // Base bit index of channel k inside the flattened result vector.
    function automatic int ch_slice(input int k, input int sample_w);
        return k * sample_w;
    endfunction

endpackage

// File: rtl/analog_scan_avg_accum.sv
// Sample accumulator: sums 2**AVG_LOG2 samples and presents the truncated mean
// combinationally on the sample that completes the block.
module avg_accum #(
    parameter int SAMPLE_W = 10,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                add,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                done,
    output logic [SAMPLE_W-1:0] result
);
    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_s;

    // Sum can never overflow: at most 2**AVG_LOG2 full-scale samples.
    assign sum_s  = acc_q + ACC_W'(sample);
    assign done   = add && (cnt_q == CNT_LAST);
    // Upper SAMPLE_W bits of the sum are the mean truncated toward zero.
    assign result = sum_s[ACC_W-1 -: SAMPLE_W];

    // Next-state: clear wins, a completed block restarts itself, otherwise accumulate.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (done) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            acc_d = sum_s;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Accumulator and sample counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/analog_scan_avg.sv
// Round-robin ADC mux scanner: requests each channel in turn, drops settling
// samples after every switch, averages accepted samples and keeps one result
// register per channel.
module analog_scan_avg
    import analog_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 10,
    parameter int AVG_LOG2 = 2,
    parameter int DISCARD  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    output logic [CH_W-1:0]            channel,
    input  logic                       new_sample,
    input  logic [SAMPLE_W-1:0]        sample,
    input  logic [CH_W-1:0]            sample_channel,
    output logic [NUM_CH*SAMPLE_W-1:0] out_data,
    output logic [NUM_CH-1:0]          out_valid,
    output logic                       update,
    output logic [CH_W-1:0]            update_ch
);
    localparam logic [CH_W-1:0] PTR_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [1:0]      DISC_LAST = 2'(DISCARD - 1);

    state_e                     state_q, state_d;
    logic [CH_W-1:0]            ptr_q, ptr_d;
    logic [1:0]                 disc_q, disc_d;
    logic [NUM_CH*SAMPLE_W-1:0] out_data_q;
    logic [NUM_CH-1:0]          out_valid_q;
    logic                       update_q;
    logic [CH_W-1:0]            update_ch_q;

    logic                       accepted_s;
    logic                       clear_s;
    logic                       add_s;
    logic                       done_s;
    logic [SAMPLE_W-1:0]        result_s;

    // Only strobes tagged with the channel currently requested count; stale ones are dropped.
    assign accepted_s = new_sample && (sample_channel == ptr_q);

    avg_accum #(
        .SAMPLE_W (SAMPLE_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_s),
        .add    (add_s),
        .sample (sample),
        .done   (done_s),
        .result (result_s)
    );

    // Scan FSM next-state: settle after each switch, then accumulate until a result completes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        disc_d  = disc_q;
        clear_s = 1'b0;
        add_s   = 1'b0;
        case (state_q)
            IDLE: begin
                clear_s = 1'b1;
                disc_d  = 2'd0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (DISCARD == 0) begin
                    state_d = ACCUM;
                end else begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                    clear_s = 1'b1;
                    disc_d  = 2'd0;
                end else if (accepted_s) begin
                    if (disc_q == DISC_LAST) begin
                        state_d = ACCUM;
                        clear_s = 1'b1;
                        disc_d  = 2'd0;
                    end else begin
                        disc_d = disc_q + 2'd1;
                    end
                end else begin
                    state_d = SETTLE;
                end
            end
            ACCUM: begin
                add_s = accepted_s;
                if (done_s) begin
                    // A completing sample is kept even if enable fell in the same cycle.
                    disc_d = 2'd0;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = ptr_q + CH_W'(1);
                    end
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (DISCARD == 0) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = SETTLE;
                    end
                end else if (!enable) begin
                    // Abort: the partial average is thrown away, the channel is kept.
                    state_d = IDLE;
                    clear_s = 1'b1;
                end else begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = IDLE;
                clear_s = 1'b1;
                disc_d  = 2'd0;
            end
        endcase
    end

    // Control registers: state, channel pointer, settle counter and the update pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            disc_q      <= 2'd0;
            update_q    <= 1'b0;
            update_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            disc_q   <= disc_d;
            update_q <= done_s;
            if (done_s) begin
                update_ch_q <= ptr_q;
            end else begin
                update_ch_q <= update_ch_q;
            end
        end
    end

    // Per-channel result registers, written in the cycle after the final accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (done_s && (ptr_q == CH_W'(k))) begin
                    out_data_q[ch_slice(k, SAMPLE_W) +: SAMPLE_W] <= result_s;
                    out_valid_q[k]                               <= 1'b1;
                end
            end
        end
    end

    assign channel   = ptr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign update    = update_q;
    assign update_ch = update_ch_q;

endmodule
